dzcpu_useq: RTL and testbench
=============================

Name: dzcpu_useq

Overview:
- Micro-sequencer of the dzcpu.
- Latches each fetched opcode byte and drives it to dzcpu_ucode_lut and dzcpu_ucode_cblut.
- Steps a micro-PC through dzcpu_ucode_rom and issues one registered micro-op per cycle to the datapath.
- Decodes each uop's next-control field to generate PC-increment pulses, flag-update strobes, 0xCB re-dispatch and end-of-flow return to fetch.

Parameters:
- UPC_W, 8, micro-PC / ROM address width.
- UOP_W, 12, micro-op word width: [11:9] next-control, [8:0] datapath payload.
- MAX_FLOW_LEN, 32, watchdog limit in issued uops (optional feature only).

Ports:
- iClock  in  1  core clock.
- iReset  in  1  synchronous, active-high reset.
- iMop  in  8  opcode byte from memory read data.
- iMopValid  in  1  iMop valid this cycle.
- iStall  in  1  datapath/memory wait; freezes sequencer.
- iFlagZ  in  1  current Z flag.
- oMop  out  8  latched opcode; drives both LUTs.
- iFlowIdx  in  8  main LUT result for oMop (combinational).
- iCbFlowIdx  in  8  CB LUT result for oMop (combinational).
- oUopAddr  out  UPC_W  ROM address (= micro-PC).
- iUop  in  UOP_W  ROM data for oUopAddr (combinational).
- oUop  out  9  registered payload issued to datapath.
- oUopValid  out  1  oUop valid this cycle.
- oIncPc  out  1  one-cycle PC increment pulse.
- oFlagUpdate  out  1  one-cycle flag-update strobe.
- oFetchReq  out  1  high in fetch states.
- oHang  out  1  sticky watchdog error (optional feature only; else tied 0).

Behaviour:
- Next-control codes, defined in the package:
  - OP=0: advance.
  - INC=1: advance + oIncPc.
  - EOF=2: end of flow.
  - INC_EOF=3: end of flow + oIncPc.
  - INC_EOF_Z=4: oIncPc; end if iFlagZ=1, else advance.
  - EOF_FU=5: end of flow + oFlagUpdate.
  - INC_EOF_FU=6: end of flow + oIncPc + oFlagUpdate.
  - JCB=7: oIncPc + CB re-dispatch.
- Reset values:
  - State FETCH; uPC=0; oMop=0.
  - oUop=0, oUopValid=0, oIncPc=0, oFlagUpdate=0, oHang=0.
  - Reset mid-flow aborts the flow the same cycle; no further uops are issued.
- FSM states: FETCH, DISPATCH, EXEC, CBFETCH, CBDISPATCH.
- FETCH:
  - oFetchReq=1.
  - On iMopValid: oMop<=iMop; go to DISPATCH.
- DISPATCH: uPC<=iFlowIdx; go to EXEC. A flow index of 0 is legal and selects the generic 1-byte flow.
- EXEC, when iStall=0:
  - Each cycle oUop<=iUop[8:0] and oUopValid<=1.
  - Side-effect pulses are registered, aligned with the issued uop.
  - Advance: uPC<=uPC+1, modulo 2^UPC_W; wrap is not an error.
  - End of flow: go to FETCH, uPC<=0.
  - JCB: go to CBFETCH.
- EXEC, when iStall=1: uPC and state hold; oUopValid=0, oIncPc=0, oFlagUpdate=0.
- CBFETCH: on iMopValid, oMop<=iMop; go to CBDISPATCH.
- CBDISPATCH: uPC<=iCbFlowIdx; go to EXEC.
- iStall in FETCH, CBFETCH or DISPATCH is ignored; iMopValid in EXEC is ignored.
- Latency:
  - Opcode accepted at cycle T → first uop valid at T+2.
  - EOF uop at cycle T → oFetchReq high at T+1.
  - Per-instruction overhead is 2 bubble cycles (fetch, dispatch).
- Chained JCB is allowed: a JCB inside a CB flow re-dispatches again.

Optional Feature:
- Macro: DZCPU_USEQ_WATCHDOG_EN.
- Defined:
  - A counter counts uops issued since the last DISPATCH/CBDISPATCH and clears on end of flow.
  - On reaching MAX_FLOW_LEN without end of flow, set oHang (sticky until iReset) and force FETCH, uPC=0.
- Undefined: no counter; oHang tied 0; flows may run indefinitely.

Decomposition:
- Package dzcpu_useq_pkg holds:
  - The next-control code constants.
  - Field slice positions (NC_MSB=11, NC_LSB=9, PAYLOAD_W=9).
  - State encodings.
- One sub-module, dzcpu_useq_nctl_dec: combinational decode of next-control plus iFlagZ into advance, end, inc, fu and jcb.
- The FSM and uPC register remain in the top.

Test Plan:
- Reset: hold iReset 3 cycles mid-EXEC → all outputs 0, oFetchReq=1 the cycle after release.
- 4-uop flow at idx 1 (INC, INC, OP, INC_EOF): iMop valid at T → oUopValid T+2..T+5; oIncPc at T+2, T+3, T+5; oFetchReq at T+6.
- INC_EOF_Z with iFlagZ=1 → flow ends, next uop not issued. With iFlagZ=0 → uPC+1 issued next cycle.
- JCB at idx 15 with CB byte 0x7C valid 1 cycle later, iCbFlowIdx=16 → uop 16 (EOF_FU) issued, oFlagUpdate=1 once, then FETCH.
- iStall high 3 cycles mid-flow → uPC frozen, oUopValid=0 for exactly 3 cycles, no duplicated or dropped uop.
- Watchdog (macro on, MAX_FLOW_LEN=32): ROM of all OP → oHang rises after 32 uops, FETCH entered; macro off → oHang stays 0.

Source files
------------

// File: rtl/dzcpu_useq_pkg.sv
// Shared definitions for the dzcpu micro-sequencer: next-control codes, uop field slices, FSM states.
package dzcpu_useq_pkg;

  localparam int NC_MSB    = 11;
  localparam int NC_LSB    = 9;
  localparam int PAYLOAD_W = 9;

  typedef enum logic [2:0] {
    NC_OP         = 3'd0,
    NC_INC        = 3'd1,
    NC_EOF        = 3'd2,
    NC_INC_EOF    = 3'd3,
    NC_INC_EOF_Z  = 3'd4,
    NC_EOF_FU     = 3'd5,
    NC_INC_EOF_FU = 3'd6,
    NC_JCB        = 3'd7
  } nctl_e;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DISPATCH   = 3'd1,
    ST_EXEC       = 3'd2,
    ST_CBFETCH    = 3'd3,
    ST_CBDISPATCH = 3'd4
  } state_e;

endpackage

// File: rtl/dzcpu_useq_nctl_dec.sv
// Decodes a uop next-control field (plus Z flag) into advance/end/inc/flag-update/CB-jump controls.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the outputs with its stall.
module dzcpu_useq_nctl_dec
  import dzcpu_useq_pkg::*;
(
  input  logic [2:0] nc,
  input  logic       flag_z,
  output logic       adv,
  output logic       fin,
  output logic       inc,
  output logic       fu,
  output logic       jcb
);

  always_comb begin
    adv = 1'b0;
    fin = 1'b0;
    inc = 1'b0;
    fu  = 1'b0;
    jcb = 1'b0;
    case (nctl_e'(nc))
      NC_OP:         adv = 1'b1;
      NC_INC:        begin adv = 1'b1; inc = 1'b1; end
      NC_EOF:        fin = 1'b1;
      NC_INC_EOF:    begin fin = 1'b1; inc = 1'b1; end
      NC_INC_EOF_Z:  begin inc = 1'b1; fin = flag_z; adv = ~flag_z; end
      NC_EOF_FU:     begin fin = 1'b1; fu = 1'b1; end
      NC_INC_EOF_FU: begin fin = 1'b1; inc = 1'b1; fu = 1'b1; end
      NC_JCB:        begin inc = 1'b1; jcb = 1'b1; end
      default:       ;
    endcase
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu micro-sequencer: latches opcodes, walks the ucode ROM, issues one registered uop per cycle.
// Latency: opcode accepted -> first uop valid 2 cycles later; watchdog via DZCPU_USEQ_WATCHDOG_EN.
// Backpressure: iStall freezes EXEC (no uop, no pulses); fetch states wait on iMopValid.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int UPC_W = 8,
  parameter int UOP_W = 12
`ifdef DZCPU_USEQ_WATCHDOG_EN
  ,
  parameter int MAX_FLOW_LEN = 32
`endif
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMop,
  input  logic             iMopValid,
  input  logic             iStall,
  input  logic             iFlagZ,
  output logic [7:0]       oMop,
  input  logic [7:0]       iFlowIdx,
  input  logic [7:0]       iCbFlowIdx,
  output logic [UPC_W-1:0] oUopAddr,
  input  logic [UOP_W-1:0] iUop,
  output logic [8:0]       oUop,
  output logic             oUopValid,
  output logic             oIncPc,
  output logic             oFlagUpdate,
  output logic             oFetchReq,
  output logic             oHang
);

  state_e                 state, state_nxt;
  logic [UPC_W-1:0]       upc, upc_nxt;
  logic [7:0]             mop_nxt;
  logic [PAYLOAD_W-1:0]   uop_nxt;
  logic                   vld_nxt, inc_nxt, fu_nxt, fetch_nxt;
  logic                   dec_adv, dec_fin, dec_inc, dec_fu, dec_jcb;

`ifdef DZCPU_USEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAX_FLOW_LEN + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hang, hang_nxt;
`endif

  dzcpu_useq_nctl_dec u_dec (
    .nc     (iUop[NC_MSB:NC_LSB]),
    .flag_z (iFlagZ),
    .adv    (dec_adv),
    .fin    (dec_fin),
    .inc    (dec_inc),
    .fu     (dec_fu),
    .jcb    (dec_jcb)
  );

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    mop_nxt   = oMop;
    uop_nxt   = oUop;
    vld_nxt   = 1'b0;
    inc_nxt   = 1'b0;
    fu_nxt    = 1'b0;
`ifdef DZCPU_USEQ_WATCHDOG_EN
    cnt_nxt   = cnt;
    hang_nxt  = hang;
`endif
    case (state)
      ST_FETCH, ST_CBFETCH: begin
        if (iMopValid) begin
          mop_nxt   = iMop;
          state_nxt = (state == ST_FETCH) ? ST_DISPATCH : ST_CBDISPATCH;
        end
      end
      ST_DISPATCH, ST_CBDISPATCH: begin
        upc_nxt   = (state == ST_DISPATCH) ? UPC_W'(iFlowIdx) : UPC_W'(iCbFlowIdx);
        state_nxt = ST_EXEC;
`ifdef DZCPU_USEQ_WATCHDOG_EN
        cnt_nxt   = '0;
`endif
      end
      ST_EXEC: begin
        if (!iStall) begin
          uop_nxt = iUop[PAYLOAD_W-1:0];
          vld_nxt = 1'b1;
          inc_nxt = dec_inc;
          fu_nxt  = dec_fu;
          if (dec_adv) upc_nxt = upc + 1'b1;
          if (dec_fin) begin
            state_nxt = ST_FETCH;
            upc_nxt   = '0;
          end else if (dec_jcb) begin
            state_nxt = ST_CBFETCH;
          end
`ifdef DZCPU_USEQ_WATCHDOG_EN
          // The uop that reaches the limit is still issued; the flow is then abandoned.
          cnt_nxt = cnt + 1'b1;
          if (dec_fin) begin
            cnt_nxt = '0;
          end else if (cnt_nxt == CNT_W'(MAX_FLOW_LEN)) begin
            hang_nxt  = 1'b1;
            state_nxt = ST_FETCH;
            upc_nxt   = '0;
            cnt_nxt   = '0;
          end
`endif
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
    // Registered so the request trails an end-of-flow uop by one cycle.
    fetch_nxt = ((state == ST_FETCH) || (state == ST_CBFETCH)) && !iMopValid;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state       <= ST_FETCH;
      upc         <= '0;
      oMop        <= '0;
      oUop        <= '0;
      oUopValid   <= 1'b0;
      oIncPc      <= 1'b0;
      oFlagUpdate <= 1'b0;
      oFetchReq   <= 1'b0;
`ifdef DZCPU_USEQ_WATCHDOG_EN
      cnt         <= '0;
      hang        <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      upc         <= upc_nxt;
      oMop        <= mop_nxt;
      oUop        <= uop_nxt;
      oUopValid   <= vld_nxt;
      oIncPc      <= inc_nxt;
      oFlagUpdate <= fu_nxt;
      oFetchReq   <= fetch_nxt;
`ifdef DZCPU_USEQ_WATCHDOG_EN
      cnt         <= cnt_nxt;
      hang        <= hang_nxt;
`endif
    end
  end

  assign oUopAddr = upc;

`ifdef DZCPU_USEQ_WATCHDOG_EN
  assign oHang = hang;
`else
  assign oHang = 1'b0;
`endif

endmodule

// File: tb/tb_dzcpu_useq.sv
// Bench for dzcpu_useq: directed flows with literal expectations, then random traffic vs a behavioural model.
module tb_dzcpu_useq;
  localparam int MAXLEN = 32;

  logic        iClock = 1'b0;
  logic        iReset, iMopValid, iStall, iFlagZ;
  logic [7:0]  iMop, oMop, iFlowIdx, iCbFlowIdx, oUopAddr;
  logic [11:0] iUop;
  logic [8:0]  oUop;
  logic        oUopValid, oIncPc, oFlagUpdate, oFetchReq, oHang;

  logic [11:0] rom   [256];
  logic [7:0]  lut   [256];
  logic [7:0]  cblut [256];

  always #5 iClock = ~iClock;

  assign iUop       = rom[oUopAddr];
  assign iFlowIdx   = lut[oMop];
  assign iCbFlowIdx = cblut[oMop];

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMopValid(iMopValid),
    .iStall(iStall), .iFlagZ(iFlagZ), .oMop(oMop), .iFlowIdx(iFlowIdx),
    .iCbFlowIdx(iCbFlowIdx), .oUopAddr(oUopAddr), .iUop(iUop), .oUop(oUop),
    .oUopValid(oUopValid), .oIncPc(oIncPc), .oFlagUpdate(oFlagUpdate),
    .oFetchReq(oFetchReq), .oHang(oHang)
  );

  int vectors = 0, compares = 0, miscompares = 0;

  // Behavioural model: phase 0 fetch, 1 dispatch, 2 exec, 3 cb fetch, 4 cb dispatch.
  int ph = 0, m_pc = 0, m_mop = 0, m_uop = 0, m_cnt = 0;
  bit m_vld = 0, m_inc = 0, m_fu = 0, m_fr = 0, m_hang = 0;

  int n_vld, n_inc, n_fu, last_uop;
  int issued[$];

  function automatic logic [11:0] mk(int code, int pay);
    return 12'((code << 9) | pay);
  endfunction

  task automatic check(string name, int act, int exp);
    compares++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit rst, bit mv, int m, bit stall, bit z);
    int u, code;
    bit done;
    if (rst) begin
      ph = 0; m_pc = 0; m_mop = 0; m_uop = 0; m_cnt = 0;
      m_vld = 0; m_inc = 0; m_fu = 0; m_fr = 0; m_hang = 0;
      return;
    end
    m_fr  = (ph == 0 || ph == 3) && !mv;
    m_vld = 0; m_inc = 0; m_fu = 0;
    case (ph)
      0, 3: if (mv) begin m_mop = m; ph = ph + 1; end
      1: begin m_pc = lut[m_mop];   m_cnt = 0; ph = 2; end
      4: begin m_pc = cblut[m_mop]; m_cnt = 0; ph = 2; end
      default: if (!stall) begin
        u     = int'(rom[m_pc]);
        code  = u >> 9;
        m_uop = u & 511;
        m_vld = 1;
        m_inc = code inside {1, 3, 4, 6, 7};
        m_fu  = (code == 5) || (code == 6);
        done  = (code inside {2, 3, 5, 6}) || (code == 4 && z);
        m_cnt++;
        if (done) begin ph = 0; m_pc = 0; m_cnt = 0; end
        else if (code == 7) ph = 3;
        else m_pc = (m_pc + 1) % 256;
`ifdef DZCPU_USEQ_WATCHDOG_EN
        if (!done && m_cnt == MAXLEN) begin m_hang = 1; ph = 0; m_pc = 0; m_cnt = 0; end
`endif
      end
    endcase
  endtask

  task automatic compare_outputs();
    check("oMop",        int'(oMop),        m_mop);
    check("oUopAddr",    int'(oUopAddr),    m_pc);
    check("oUop",        int'(oUop),        m_uop);
    check("oUopValid",   int'(oUopValid),   int'(m_vld));
    check("oIncPc",      int'(oIncPc),      int'(m_inc));
    check("oFlagUpdate", int'(oFlagUpdate), int'(m_fu));
    check("oFetchReq",   int'(oFetchReq),   int'(m_fr));
    check("oHang",       int'(oHang),       int'(m_hang));
  endtask

  task automatic tick(bit rst, bit mv, int m, bit stall, bit z);
    iReset = rst; iMopValid = mv; iMop = 8'(m); iStall = stall; iFlagZ = z;
    model_step(rst, mv, m, stall, z);
    @(posedge iClock);
    #1;
    vectors++;
    compare_outputs();
    if (oUopValid) begin n_vld++; last_uop = int'(oUop); issued.push_back(int'(oUop)); end
    if (oIncPc) n_inc++;
    if (oFlagUpdate) n_fu++;
  endtask

  task automatic clear_counts();
    n_vld = 0; n_inc = 0; n_fu = 0; last_uop = -1;
    issued.delete();
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 60 && !oFetchReq; i++) tick(0, 0, 0, 0, 0);
    check("wait_fetch", int'(oFetchReq), 1);
  endtask

  task automatic run_flow(int op, bit z, int ncyc);
    wait_fetch();
    clear_counts();
    tick(0, 1, op, 0, z);
    for (int i = 0; i < ncyc; i++) tick(0, 0, 0, 0, z);
  endtask

  task automatic setup_tables();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 12'($urandom); lut[i] = 8'($urandom); cblut[i] = 8'($urandom);
    end
    lut[1] = 8'd1;
    rom[1] = mk(1, 'h011); rom[2] = mk(1, 'h022); rom[3] = mk(0, 'h033); rom[4] = mk(3, 'h044);
    lut[8] = 8'd8;
    rom[8] = mk(0, 'h081); rom[9] = mk(4, 'h092); rom[10] = mk(2, 'h0A3);
    lut[8'hCB] = 8'd15; rom[15] = mk(7, 'h0F0);
    cblut[8'h7C] = 8'd16; rom[16] = mk(5, 'h100);
    lut[32] = 8'd32;
    for (int i = 0; i < 5; i++) rom[32+i] = mk(0, 'h120 + i);
    rom[37] = mk(2, 'h125);
  endtask

  initial begin
    int ev_vld[7], ev_inc[7], ev_fr[7];
    int exp_seq[6];
    ev_vld = '{0, 0, 1, 1, 1, 1, 0};
    ev_inc = '{0, 0, 1, 1, 0, 1, 0};
    ev_fr  = '{0, 0, 0, 0, 0, 0, 1};
    exp_seq = '{'h120, 'h121, 'h122, 'h123, 'h124, 'h125};
    setup_tables();
    clear_counts();

    // Reset values and first fetch request.
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("rst_vld", int'(oUopValid), 0);
    check("rst_fr", int'(oFetchReq), 0);
    check("rst_mop", int'(oMop), 0);
    check("rst_addr", int'(oUopAddr), 0);
    tick(0, 0, 0, 0, 0);
    check("rst_release_fr", int'(oFetchReq), 1);

    // 4-uop flow: INC, INC, OP, INC_EOF.
    clear_counts();
    tick(0, 1, 1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick(0, 0, 0, 0, 0);
      check("flowA_vld", int'(oUopValid), ev_vld[k]);
      check("flowA_inc", int'(oIncPc), ev_inc[k]);
      check("flowA_fr", int'(oFetchReq), ev_fr[k]);
      if (k == 2) check("flowA_first", int'(oUop), 'h011);
      if (k == 5) check("flowA_last", int'(oUop), 'h044);
    end

    // INC_EOF_Z taken and not taken.
    run_flow(8, 1, 8);
    check("eofz1_n", n_vld, 2);
    check("eofz1_last", last_uop, 'h092);
    run_flow(8, 0, 8);
    check("eofz0_n", n_vld, 3);
    check("eofz0_last", last_uop, 'h0A3);
    check("eofz0_inc", n_inc, 1);

    // JCB re-dispatch through the CB table.
    wait_fetch();
    clear_counts();
    tick(0, 1, 'hCB, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    check("jcb_uop", int'(oUop), 'h0F0);
    tick(0, 1, 'h7C, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
    check("jcb_n", n_vld, 2);
    check("jcb_fu", n_fu, 1);
    check("jcb_inc", n_inc, 1);
    check("jcb_last", last_uop, 'h100);
    check("jcb_mop", int'(oMop), 'h7C);
    check("jcb_fr", int'(oFetchReq), 1);

    // Three stall cycles mid-flow.
    wait_fetch();
    clear_counts();
    tick(0, 1, 32, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 0);
      check("stall_vld", int'(oUopValid), 0);
      check("stall_addr", int'(oUopAddr), 34);
    end
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);
    check("stall_n", n_vld, 6);
    for (int i = 0; i < 6 && i < issued.size(); i++) check("stall_seq", issued[i], exp_seq[i]);

    // Reset mid-EXEC.
    wait_fetch();
    clear_counts();
    tick(0, 1, 32, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0);
      check("midrst_vld", int'(oUopValid), 0);
      check("midrst_uop", int'(oUop), 0);
      check("midrst_inc", int'(oIncPc), 0);
    end
    tick(0, 0, 0, 0, 0);
    check("midrst_fr", int'(oFetchReq), 1);
    check("midrst_vld2", int'(oUopValid), 0);

    // Endless OP flow: watchdog behaviour.
    for (int i = 0; i < 256; i++) rom[i] = mk(0, i);
    clear_counts();
    tick(0, 1, 5, 0, 0);
    for (int i = 0; i < 40; i++) tick(0, 0, 0, 0, 0);
`ifdef DZCPU_USEQ_WATCHDOG_EN
    check("wd_n", n_vld, MAXLEN);
    check("wd_hang", int'(oHang), 1);
    check("wd_fr", int'(oFetchReq), 1);
`else
    check("nowd_n", n_vld, 39);
    check("nowd_hang", int'(oHang), 0);
`endif
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("hang_clear", int'(oHang), 0);
    setup_tables();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
